// File: rtl/gcd_requester.sv
// gcd_requester: req/ack initiator for the GCD core, with valid/ready operand and result streams; GCD_REQ_TIMEOUT_EN adds a per-phase watchdog
module gcd_requester #(
   parameter int OP_W        = 8,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_a,
   input  logic [OP_W-1:0]   in_b,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [OP_W-1:0]   res_c,
   output logic              err,
   output logic              req,
   output logic [2*OP_W-1:0] AB,
   input  logic              ack,
   input  logic [OP_W-1:0]   C
);
   typedef enum logic [1:0] {IDLE, REQ, REL, DONE} state_t;
   state_t              state_q, state_d;
   logic                req_q, req_d;
   logic                res_valid_q, res_valid_d;
   logic [2*OP_W-1:0]   ab_q, ab_d;
   logic [OP_W-1:0]     res_c_q, res_c_d;
   logic                accept;
   logic                wd_hit;
   assign in_ready  = (state_q == IDLE) && !ack;
   assign accept    = in_valid && in_ready;
   assign req       = req_q;
   assign res_valid = res_valid_q;
   assign AB        = ab_q;
   assign res_c     = res_c_q;
`ifdef GCD_REQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, err_d;
   assign wd_hit = (state_q == REQ || state_q == REL) && wd_q == WD_W'(TIMEOUT_CYC - 1);
   assign err    = err_q;
   // watchdog restarts on every phase change and counts while a phase persists
   always_comb begin
      wd_d  = (state_d == state_q && (state_q == REQ || state_q == REL)) ? wd_q + 1'b1 : '0;
      err_d = err_q | (wd_hit && ((state_q == REQ && !ack) || (state_q == REL && ack)));
   end
   // watchdog and sticky error registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end
`else
   assign wd_hit = 1'b0;
   assign err    = (TIMEOUT_CYC < 0);
`endif
   // handshake sequencing; a zero operand short-circuits straight to DONE
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      res_valid_d = res_valid_q;
      ab_d        = ab_q;
      res_c_d     = res_c_q;
      case (state_q)
         IDLE: if (accept) begin
            ab_d = {in_b, in_a};
            if (in_a == '0 || in_b == '0) begin
               res_c_d     = in_a | in_b;
               res_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               req_d   = 1'b1;
               state_d = REQ;
            end
         end
         REQ: if (ack) begin
            res_c_d = C;
            req_d   = 1'b0;
            state_d = REL;
         end else if (wd_hit) begin
            req_d       = 1'b0;
            res_c_d     = '0;
            res_valid_d = 1'b1;
            state_d     = DONE;
         end
         REL: if (!ack || wd_hit) begin
            res_c_d     = ack ? '0 : res_c_q;
            res_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: if (res_ready) begin
            res_valid_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         req_q       <= 1'b0;
         res_valid_q <= 1'b0;
         ab_q        <= '0;
         res_c_q     <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         res_valid_q <= res_valid_d;
         ab_q        <= ab_d;
         res_c_q     <= res_c_d;
      end
   end
endmodule

// File: tb/tb_gcd_requester.sv
// tb_gcd_requester: directed checks of gcd_requester against a behavioural GCD core
module tb_gcd_requester;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_a = '0;
   logic [7:0]  in_b = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [7:0]  res_c;
   logic        err;
   logic        req;
   logic [15:0] AB;
   logic        ack = 1'b0;
   logic [7:0]  C = '0;
   int          vectors = 0;
   int          errors = 0;
   int          k_cyc = 5;
   bit          manual = 1'b0;
   bit          core_rst = 1'b0;
   int          core_cnt = 0;
   bit          core_dly = 1'b0;
   int          lat;
   bit          saw_req, ab_ok, hold_ok, acc;

   gcd_requester #(.OP_W(8), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .res_valid(res_valid), .res_ready(res_ready),
      .res_c(res_c), .err(err), .req(req), .AB(AB), .ack(ack), .C(C)
   );

   always #5 clk = ~clk;

   // core model: raises ack k_cyc cycles into req, drops it one cycle after req falls
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (core_rst) begin
            ack = 1'b0;
            core_cnt = 0;
            core_dly = 1'b0;
         end else if (!manual) begin
            if (req && !ack) begin
               if (core_cnt == k_cyc) begin
                  ack = 1'b1;
                  core_cnt = 0;
               end else core_cnt++;
            end else if (!req && ack) begin
               if (core_dly) begin
                  ack = 1'b0;
                  core_dly = 1'b0;
               end else core_dly = 1'b1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 60; t++) begin
         acc = in_ready;
         @(posedge clk);
         if (acc) break;
         @(negedge clk);
      end
      #1 in_valid = 1'b0;
      check("accept", acc, 1);
   endtask

   task automatic wait_valid(input logic [15:0] ab_exp);
      lat = 0;
      saw_req = req;
      ab_ok = (AB === ab_exp);
      while (!res_valid && lat < 400) begin
         @(posedge clk);
         #1;
         lat++;
         if (req) saw_req = 1'b1;
         if (AB !== ab_exp) ab_ok = 1'b0;
      end
   endtask

   task automatic pop();
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      check("pop_valid", res_valid, 0);
      check("pop_ready", in_ready, 1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_req", req, 0);
      check("rst_ab", AB, 0);
      check("rst_valid", res_valid, 0);
      check("rst_c", res_c, 0);
      check("rst_err", err, 0);
      check("rst_ready", in_ready, 1);
      @(negedge clk);
      reset = 1'b0;
      // 48,18 with ack after 5 cycles
      k_cyc = 5;
      C = 8'd6;
      send(8'd48, 8'd18);
      wait_valid(16'h1230);
      check("t1_lat", lat, 8);
      check("t1_c", res_c, 6);
      check("t1_req", saw_req, 1);
      check("t1_ab", ab_ok, 1);
      // result held while downstream stalls; new operands ignored
      hold_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_a = 8'(i + 1);
         in_b = 8'd3;
         @(posedge clk);
         #1;
         if (!(res_valid === 1'b1 && res_c === 8'd6 && in_ready === 1'b0 && AB === 16'h1230 && req === 1'b0))
            hold_ok = 1'b0;
      end
      in_valid = 1'b0;
      check("t3_hold", hold_ok, 1);
      pop();
      // zero operands bypass the core
      send(8'd0, 8'd35);
      wait_valid(16'h2300);
      check("t2_lat", lat, 0);
      check("t2_c", res_c, 35);
      check("t2_req", saw_req, 0);
      pop();
      send(8'd0, 8'd0);
      wait_valid(16'h0000);
      check("t2_zz_lat", lat, 0);
      check("t2_zz_c", res_c, 0);
      pop();
      send(8'd12, 8'd0);
      wait_valid(16'h000c);
      check("t2_a_c", res_c, 12);
      check("t2_a_req", saw_req, 0);
      pop();
      // stale ack in IDLE blocks acceptance
      @(negedge clk);
      manual = 1'b1;
      ack = 1'b1;
      in_a = 8'd9;
      in_b = 8'd6;
      in_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("t4_ready", in_ready, 0);
      check("t4_req", req, 0);
      check("t4_ab", AB, 16'h000c);
      @(negedge clk);
      ack = 1'b0;
      manual = 1'b0;
      in_valid = 1'b0;
      k_cyc = 2;
      C = 8'd3;
      send(8'd9, 8'd6);
      wait_valid(16'h0609);
      check("t4_lat", lat, 5);
      check("t4_c", res_c, 3);
      pop();
      // reset pulse in REQ discards the operation
      k_cyc = 20;
      C = 8'd99;
      send(8'd48, 8'd18);
      repeat (3) @(posedge clk);
      #1;
      check("t5_inreq", req, 1);
      @(negedge clk);
      reset = 1'b1;
      core_rst = 1'b1;
      @(posedge clk);
      #1;
      check("t5_req", req, 0);
      check("t5_valid", res_valid, 0);
      check("t5_ab", AB, 0);
      @(negedge clk);
      reset = 1'b0;
      core_rst = 1'b0;
      #1;
      check("t5_ready", in_ready, 1);
      k_cyc = 3;
      C = 8'd7;
      send(8'd21, 8'd14);
      wait_valid(16'h0e15);
      check("t5_lat", lat, 6);
      check("t5_c", res_c, 7);
      pop();
`ifdef GCD_REQ_TIMEOUT_EN
      // core never answers: watchdog aborts after 16 cycles of req
      @(negedge clk);
      manual = 1'b1;
      ack = 1'b0;
      send(8'd5, 8'd10);
      wait_valid(16'h0a05);
      check("t6_lat", lat, 16);
      check("t6_req", req, 0);
      check("t6_err", err, 1);
      check("t6_c", res_c, 0);
      pop();
      check("t6_sticky", err, 1);
`else
      check("t6_err_tied", err, 0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
